// File: rtl/roll_pkg.sv
// Shared types and default constants for the roll sequencer, the 4-bit
// generator and the seven-segment decoder.
package roll_pkg;

    typedef logic [3:0] value_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        SETTLE = 2'd2
    } roll_state_e;

    localparam int unsigned DEF_BASE_INTERVAL = 2_500_000;
    localparam int unsigned DEF_INC_INTERVAL  = 1_250_000;
    localparam int unsigned DEF_NUM_STEPS     = 16;
    localparam int unsigned DEF_HIST_DEPTH    = 8;

endpackage

// File: rtl/roll_interval_timer.sv
// Decelerating step schedule: step k fires BASE_INTERVAL + k*INC_INTERVAL
// cycles after the previous one (or after clear for k = 0). last_o marks
// the final step of a roll.
module roll_interval_timer
    import roll_pkg::*;
#(
    parameter int unsigned BASE_INTERVAL = DEF_BASE_INTERVAL,
    parameter int unsigned INC_INTERVAL  = DEF_INC_INTERVAL,
    parameter int unsigned NUM_STEPS     = DEF_NUM_STEPS
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic step_o,
    output logic last_o
);

    localparam logic [63:0] MAX_INTERVAL =
        64'(BASE_INTERVAL) + 64'(NUM_STEPS - 1) * 64'(INC_INTERVAL);
    localparam int CW = $clog2(MAX_INTERVAL + 64'd1);
    localparam int KW = $clog2(NUM_STEPS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [63:0]   limit;
    logic          hit;

    // Terminal count for the current step, evaluated wide so the product never truncates
    always_comb begin
        limit = 64'(BASE_INTERVAL) + 64'(k_q) * 64'(INC_INTERVAL) - 64'd1;
        hit   = (64'(cnt_q) == limit);
    end

    assign step_o = enable_i & hit;
    assign last_o = step_o & (k_q == KW'(NUM_STEPS - 1));

    // Counter advance: clear wins, otherwise count up and roll over into the next step
    always_comb begin
        cnt_d = cnt_q;
        k_d   = k_q;
        if (clear_i) begin
            cnt_d = '0;
            k_d   = '0;
        end else if (enable_i) begin
            if (hit) begin
                cnt_d = '0;
                k_d   = k_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Interval counter and step index registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            k_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: rtl/roll_controller.sv
// Roll sequencer: turns start/prev/next pulses into a decelerating train of
// generator advance strobes, captures the settled value and drives the display.
// Optional feature macro ROLL_HISTORY_EN adds a circular result history that
// prev/next browse; without it the display holds the last captured result.
module roll_controller
    import roll_pkg::*;
#(
    parameter int unsigned BASE_INTERVAL = DEF_BASE_INTERVAL,
    parameter int unsigned INC_INTERVAL  = DEF_INC_INTERVAL,
    parameter int unsigned NUM_STEPS     = DEF_NUM_STEPS,
    parameter int unsigned HIST_DEPTH    = DEF_HIST_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_prev,
    input  logic                          i_next,
    input  logic [3:0]                    i_value,
    output logic                          o_step,
    output logic [3:0]                    o_value,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(HIST_DEPTH)-1:0] o_hist_idx
);

    localparam int IW = $clog2(HIST_DEPTH);

    roll_state_e state_q, state_d;
    logic        timerClear;
    logic        timerEnable;
    logic        timerStep;
    logic        timerLast;
    logic        capture;
    value_t      live_q;
    logic        done_q;
    value_t      idleValue;

    roll_interval_timer #(
        .BASE_INTERVAL (BASE_INTERVAL),
        .INC_INTERVAL  (INC_INTERVAL),
        .NUM_STEPS     (NUM_STEPS)
    ) u_timer (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .clear_i  (timerClear),
        .enable_i (timerEnable),
        .step_o   (timerStep),
        .last_o   (timerLast)
    );

    assign timerEnable = (state_q == ROLL);
    assign capture     = (state_q == SETTLE) && !i_start;

    // Next-state logic; a start anywhere restarts the schedule from step 0
    always_comb begin
        state_d    = state_q;
        timerClear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = ROLL;
                    timerClear = 1'b1;
                end
            end
            ROLL: begin
                if (i_start) begin
                    timerClear = 1'b1;
                end else if (timerLast) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (i_start) begin
                    state_d    = ROLL;
                    timerClear = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, delayed generator value and the result-captured pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            live_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= i_value;
            done_q  <= capture;
        end
    end

`ifdef ROLL_HISTORY_EN
    localparam int CNTW = $clog2(HIST_DEPTH + 1);

    value_t          hist_q [HIST_DEPTH];
    logic [IW-1:0]   wrPtr_q;
    logic [IW-1:0]   offset_q, offset_d;
    logic [IW-1:0]   rdPtr;
    logic [CNTW-1:0] count_q;

    // Browse offset: a capture snaps back to newest, prev/next only act in IDLE with a non-empty history
    always_comb begin
        offset_d = offset_q;
        if (capture) begin
            offset_d = '0;
        end else if ((state_q == IDLE) && !i_start && (count_q != '0)) begin
            if (i_prev && !i_next && ((CNTW'(offset_q) + CNTW'(1)) < count_q)) begin
                offset_d = offset_q + 1'b1;
            end else if (i_next && !i_prev && (offset_q != '0)) begin
                offset_d = offset_q - 1'b1;
            end
        end
    end

    // Write pointer, saturating fill count and browse offset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrPtr_q  <= '0;
            count_q  <= '0;
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
            if (capture) begin
                wrPtr_q <= wrPtr_q + 1'b1;
                if (count_q != CNTW'(HIST_DEPTH)) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    // History storage; the fill count says which entries are meaningful, so no reset needed
    always_ff @(posedge i_clk) begin
        if (capture) begin
            hist_q[wrPtr_q] <= i_value;
        end
    end

    assign rdPtr      = wrPtr_q - IW'(1) - offset_q;
    assign idleValue  = (count_q == '0) ? value_t'(0) : hist_q[rdPtr];
    assign o_hist_idx = offset_q;
`else
    value_t result_q;
    logic   unused_browse;

    // Last captured result, shown while idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
        end else if (capture) begin
            result_q <= i_value;
        end
    end

    assign unused_browse = i_prev ^ i_next;
    assign idleValue     = result_q;
    assign o_hist_idx    = '0;
`endif

    assign o_step  = timerStep;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;
    assign o_value = (state_q == IDLE) ? idleValue : live_q;

endmodule

// File: tb/tb_roll_controller.sv
// Scoreboard bench for roll_controller with BASE=4, INC=2, STEPS=3, DEPTH=4.
// Expectations follow ROLL_HISTORY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_roll_controller;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       prev;
    logic       next;
    logic [3:0] genVal = 4'd0;
    logic       loadEn = 1'b0;
    logic [3:0] loadVal = 4'd0;

    logic       oStep;
    logic [3:0] oValue;
    logic       oBusy;
    logic       oDone;
    logic [1:0] oHistIdx;

    int cycleNo = 0;
    int total = 0;
    int bad = 0;
    int stepQ[$];
    int doneCycleQ[$];
    int doneValueQ[$];

    roll_controller #(
        .BASE_INTERVAL (4),
        .INC_INTERVAL  (2),
        .NUM_STEPS     (3),
        .HIST_DEPTH    (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_start    (start),
        .i_prev     (prev),
        .i_next     (next),
        .i_value    (genVal),
        .o_step     (oStep),
        .o_value    (oValue),
        .o_busy     (oBusy),
        .o_done     (oDone),
        .o_hist_idx (oHistIdx)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Absolute edge counter used to timestamp DUT events
    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Generator model: preloadable +1 counter advanced by each step strobe
    always @(posedge clk) begin
        if (loadEn) genVal <= loadVal;
        else if (oStep) genVal <= genVal + 4'd1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every step and done pulse is matched against the scoreboard queues
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (oStep) begin
                if (stepQ.size() == 0) checkOutput("unexpected_step", cycleNo, -1);
                else checkOutput("step_cycle", cycleNo, stepQ.pop_front());
            end
            if (oDone) begin
                if (doneCycleQ.size() == 0) begin
                    checkOutput("unexpected_done", cycleNo, -1);
                end else begin
                    checkOutput("done_cycle", cycleNo, doneCycleQ.pop_front());
                    checkOutput("done_value", int'(oValue), doneValueQ.pop_front());
                end
            end
        end
    end

    // Drive one set of pulses for exactly one sampling edge; returns that edge number
    task automatic applyStimulus(input logic s, input logic p, input logic n, output int edgeNo);
        @(negedge clk);
        start = s;
        prev  = p;
        next  = n;
        @(posedge clk);
        #1;
        edgeNo = cycleNo;
        start = 1'b0;
        prev  = 1'b0;
        next  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loadGen(input logic [3:0] v);
        @(negedge clk);
        loadVal = v;
        loadEn  = 1'b1;
        @(posedge clk);
        #1;
        loadEn = 1'b0;
    endtask

    // Steps land in relative cycles 4, 10, 18 and done in cycle 20 (cycle r = edge s+r-1)
    task automatic expectRoll(input int s, input int value);
        stepQ.push_back(s + 3);
        stepQ.push_back(s + 9);
        stepQ.push_back(s + 17);
        doneCycleQ.push_back(s + 19);
        doneValueQ.push_back(value);
    endtask

    task automatic flushExpect();
        stepQ.delete();
        doneCycleQ.delete();
        doneValueQ.delete();
    endtask

    task automatic doReset();
        rstN  = 1'b0;
        start = 1'b0;
        prev  = 1'b0;
        next  = 1'b0;
        flushExpect();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag, input int value, input int idx);
        checkOutput({tag, "_value"}, int'(oValue), value);
        checkOutput({tag, "_idx"}, int'(oHistIdx), idx);
    endtask

    initial begin
        int s;
        int s2;
`ifdef ROLL_HISTORY_EN
        int prevVal[4]  = '{4, 3, 2, 2};
        int prevIdx[4]  = '{1, 2, 3, 3};
        int nextVal[5]  = '{3, 4, 5, 5, 5};
        int nextIdx[5]  = '{2, 1, 0, 0, 0};
        int midIdx = 1;
`else
        int prevVal[4]  = '{5, 5, 5, 5};
        int prevIdx[4]  = '{0, 0, 0, 0};
        int nextVal[5]  = '{5, 5, 5, 5, 5};
        int nextIdx[5]  = '{0, 0, 0, 0, 0};
        int midIdx = 0;
`endif

        $display("[TB] roll_controller bench starting");
        doReset();
        checkOutput("reset_step", int'(oStep), 0);
        checkOutput("reset_value", int'(oValue), 0);
        checkOutput("reset_busy", int'(oBusy), 0);
        checkOutput("reset_done", int'(oDone), 0);
        checkOutput("reset_idx", int'(oHistIdx), 0);

        // Basic roll from 5: result 8, busy in cycles 1..19
        loadGen(4'd5);
        checkOutput("busy_before", int'(oBusy), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, s);
        expectRoll(s, 8);
        for (int r = 1; r <= 21; r++) begin
            checkOutput($sformatf("busy_c%0d", r), int'(oBusy), (r <= 19) ? 1 : 0);
            waitCycles(1);
        end
        checkIdle("roll1", 8, 0);
        checkOutput("roll1_pending", stepQ.size() + doneCycleQ.size(), 0);

        // Restart in cycle 12: first roll never completes, schedule restarts
        loadGen(4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, s);
        expectRoll(s, 99);
        waitCycles(11);
        applyStimulus(1'b1, 1'b0, 1'b0, s2);
        checkOutput("restart_edge", s2 - s, 12);
        checkOutput("restart_steps_seen", stepQ.size(), 1);
        flushExpect();
        expectRoll(s2, 5);
        waitCycles(25);
        checkOutput("restart_pending", stepQ.size() + doneCycleQ.size(), 0);
        checkIdle("restart", 5, 0);

        // Empty history after reset: browsing changes nothing
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, s);
        checkIdle("empty_prev", 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, s);
        checkIdle("empty_next", 0, 0);

        // Five rolls with results 1..5, then browse
        for (int r = 1; r <= 5; r++) begin
            loadGen(4'(r - 3));
            applyStimulus(1'b1, 1'b0, 1'b0, s);
            expectRoll(s, r);
            waitCycles(22);
        end
        checkIdle("five_rolls", 5, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, s);
            checkIdle($sformatf("prev%0d", i), prevVal[i], prevIdx[i]);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, s);
            checkIdle($sformatf("next%0d", i), nextVal[i], nextIdx[i]);
        end

        // Start coinciding with prev: roll starts, offset held until done
        applyStimulus(1'b0, 1'b1, 1'b0, s);
        checkOutput("pre_start_idx", int'(oHistIdx), midIdx);
        loadGen(4'd6);
        applyStimulus(1'b1, 1'b1, 1'b0, s);
        expectRoll(s, 9);
        checkOutput("start_prev_busy", int'(oBusy), 1);
        waitCycles(5);
        checkOutput("start_prev_idx_mid", int'(oHistIdx), midIdx);
        waitCycles(17);
        checkIdle("start_prev_after", 9, 0);

        // Asynchronous reset in cycle 11 of a roll
        loadGen(4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, s);
        expectRoll(s, 3);
        waitCycles(10);
        checkOutput("mid_roll_busy", int'(oBusy), 1);
        rstN = 1'b0;
        #1;
        checkOutput("async_busy", int'(oBusy), 0);
        checkOutput("async_step", int'(oStep), 0);
        flushExpect();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_busy", int'(oBusy), 0);
        checkOutput("post_rst_done", int'(oDone), 0);
        checkOutput("post_rst_step", int'(oStep), 0);
        checkIdle("post_rst", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, s);
        checkIdle("post_rst_prev", 0, 0);

        waitCycles(5);
        checkOutput("final_pending", stepQ.size() + doneCycleQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roll_controller.md
# roll_controller

Sequencer for the 4-bit random-number datapath on the DE2-115 lab board. It turns the debounced start/prev/next pulses into a decelerating train of single-cycle advance strobes to the generator and captures the settled result. It keeps a circular history of past results that prev/next browse. It sits between the Debounce instances and the seven-segment decoder; its `o_value` drives the display.

## Interface
- `BASE_INTERVAL`, default 2_500_000: cycles before the first step (50 ms at 50 MHz).
- `INC_INTERVAL`, default 1_250_000: extra cycles added to each successive step interval.
- `NUM_STEPS`, default 16: advance strobes per roll, ≥1.
- `HIST_DEPTH`, default 8: history entries, power of two, ≥2.

- `i_clk`, input, 1: system clock (CLOCK_50). Single clock domain.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_start`, input, 1: one-cycle pulse, begin/restart a roll.
- `i_prev`, input, 1: one-cycle pulse, show older history entry.
- `i_next`, input, 1: one-cycle pulse, show newer history entry.
- `i_value`, input, 4: current generator output.
- `o_step`, output, 1: one-cycle advance strobe to the generator.
- `o_value`, output, 4: value to display.
- `o_busy`, output, 1: high while rolling.
- `o_done`, output, 1: one-cycle pulse when a result is captured.
- `o_hist_idx`, output, $clog2(HIST_DEPTH): browse offset (0 = newest).

## Operation
- States: IDLE, ROLL, SETTLE.
- Reset values: state IDLE; `o_step`=0, `o_value`=0, `o_busy`=0, `o_done`=0, `o_hist_idx`=0; history count=0, write pointer=0.
- Reset is asynchronous. Asserting it mid-roll drops `o_step` and `o_busy` immediately. No partial result is stored.

IDLE
- `i_start` → ROLL, with the step index k and the interval counter cleared.
- `o_value` = history[newest − offset], or 0 when the history is empty.

ROLL
- The interval counter counts up. When it reaches `BASE_INTERVAL + k*INC_INTERVAL − 1`:
  - `o_step` is high for exactly that cycle,
  - the counter is cleared,
  - k increments.
- After step `NUM_STEPS−1` is issued → SETTLE.
- `o_value` = `i_value` registered, a 1-cycle delay.

SETTLE
- One cycle; `i_value` is sampled here, since the generator updated on the last step edge.
- Next cycle: the sample is pushed to history, `o_value` updates to it, `o_done` pulses, offset=0 → IDLE.

Start and browse rules
- `i_start` during ROLL or SETTLE restarts the schedule at k=0 with no push.
- `i_prev` and `i_next` are ignored outside IDLE.
- When `i_start` coincides with `i_prev`/`i_next`, start wins.

History
- Circular buffer; the write pointer wraps modulo `HIST_DEPTH`.
- The count saturates at `HIST_DEPTH`; the oldest entry is overwritten.
- `i_prev`: offset+1, saturating at count−1.
- `i_next`: offset−1, saturating at 0.
- With an empty history, both are ignored.
- `i_prev` and `i_next` together: no change.

Widths
- Interval counter: $clog2(BASE_INTERVAL+(NUM_STEPS−1)*INC_INTERVAL+1).
- k: $clog2(NUM_STEPS+1).
- Unsigned arithmetic throughout; the interval product is computed at full width with no truncation.

## Timing
- Let cycle 0 be the edge sampling `i_start`. The first `o_step` is high in cycle `BASE_INTERVAL`.
- Step k follows step k−1 by `BASE_INTERVAL + k*INC_INTERVAL` cycles.
- `o_busy` is high from cycle 1 through the SETTLE cycle.
- `o_done` and the new `o_value` appear 2 cycles after the last `o_step`.
- A browse takes effect on `o_value`/`o_hist_idx` the cycle after the pulse.

## Configuration
- `ROLL_HISTORY_EN` defined: history buffer and prev/next browsing as above.
- Not defined:
  - no buffer is instantiated,
  - `i_prev`/`i_next` are ignored,
  - `o_hist_idx` is tied to 0,
  - `o_value` in IDLE holds the last captured result (0 after reset).

## Structure
- Shared package `roll_pkg` holds:
  - the state enum `roll_state_e` (IDLE, ROLL, SETTLE),
  - default parameter constants,
  - the `value_t` 4-bit typedef shared with the generator and decoder.
- Sub-module `roll_interval_timer` holds the interval counter, k index and step-strobe generation. Its inputs are a clear and an enable; its outputs are `step` and `last`.

## Test plan
All scenarios use BASE_INTERVAL=4, INC_INTERVAL=2, NUM_STEPS=3, HIST_DEPTH=4.
- Reset, then `i_start` at cycle 0, with the generator a +1 counter from 5 → `o_step` in cycles 4, 10, 18; `o_done` in cycle 20; `o_value`=8; `o_busy` high in cycles 1–19.
- `i_start` again in cycle 12 of a roll → no `o_done` from the first roll; steps in cycles 16, 22, 30 (relative schedule restarted).
- Five completed rolls with results 1,2,3,4,5, then `i_prev` ×4 → `o_value` 4,3,2,2 (saturates at 2, since 1 was overwritten); `o_hist_idx` ends at 3. Then `i_next` ×5 → `o_value`=5, idx=0.
- After reset, `i_prev`/`i_next` → `o_value` stays 0, idx stays 0.
- `i_start` together with `i_prev` in IDLE → roll starts, offset unchanged until `o_done` resets it to 0.
- Assert `i_rst_n` low in cycle 11 of a roll → `o_step`/`o_busy` low in the same cycle; after release all outputs are 0 and the history is empty.
